// File: rtl/slave_tx_arbiter_if.sv
// slave_tx_arbiter_if
//   Bundle of the shared return-line signals between NUM_SLAVES serial
//   transmitters and one master.
//   slave modport  : the arbiter's view (takes requests, drives grant/mux).
//   master modport : the environment's view (drives requests, observes grant).
//   s_valid      per-slave request
//   s_tx_done    per-slave end-of-frame pulse
//   s_tx_data    per-slave serial bit
//   m_ready      master ready
//   m_ready_out  per-slave gated copy of m_ready
//   tx_data      muxed serial line to master
//   grant        one-hot owner, zero when none
//   grant_id     binary index of last/current owner
//   busy         high while a transfer is in progress
//   timeout_err  one-cycle pulse on forced release
interface slave_tx_arbiter_if #(
  parameter int NUM_SLAVES = 3
);
  logic [NUM_SLAVES-1:0]         s_valid;
  logic [NUM_SLAVES-1:0]         s_tx_done;
  logic [NUM_SLAVES-1:0]         s_tx_data;
  logic                          m_ready;
  logic [NUM_SLAVES-1:0]         m_ready_out;
  logic                          tx_data;
  logic [NUM_SLAVES-1:0]         grant;
  logic [$clog2(NUM_SLAVES)-1:0] grant_id;
  logic                          busy;
  logic                          timeout_err;

  modport slave (
    input  s_valid, s_tx_done, s_tx_data, m_ready,
    output m_ready_out, tx_data, grant, grant_id, busy, timeout_err
  );

  modport master (
    output s_valid, s_tx_done, s_tx_data, m_ready,
    input  m_ready_out, tx_data, grant, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/slave_tx_arbiter.sv
// slave_tx_arbiter
//   Round-robin arbiter giving NUM_SLAVES serial transmitters turns on one
//   return line. A winner is picked from IDLE on the edge a request is seen,
//   owns the line until it pulses its own s_tx_done (or TIMEOUT_CYCLES XFER
//   cycles elapse), then a single RELEASE cycle separates it from the next
//   owner.
//   Ports:
//     clk  clock, rising edge
//     rst  asynchronous active-high reset
//     bus  slave_tx_arbiter_if.slave (requests in, grant / muxed data out)

// Per-slave gating: the lane only passes ready / data while it holds grant.
module slave_tx_arbiter_lane (
  input  logic gnt,
  input  logic m_ready,
  input  logic s_tx_data,
  output logic m_ready_out,
  output logic tx_bit
);
  assign m_ready_out = gnt & m_ready;
  assign tx_bit      = gnt & s_tx_data;
endmodule

module slave_tx_arbiter #(
  parameter int NUM_SLAVES     = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  slave_tx_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_SLAVES);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen during the last allowed XFER cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [NUM_SLAVES-1:0] ONE = {{(NUM_SLAVES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                state;
  logic [NUM_SLAVES-1:0] grant_q;
  logic [IDW-1:0]        gid_q;
  logic                  busy_q;
  logic                  te_q;
  logic [CW-1:0]         cnt;

  logic                  win_found;
  logic [IDW-1:0]        win_id;
  logic                  owner_done;
  logic                  cnt_expired;
  logic [NUM_SLAVES-1:0] mro;
  logic [NUM_SLAVES-1:0] tx_bits;

  // Round-robin search starting just after the last owner, wrapping once.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_SLAVES; k++) begin
      idx = (int'(gid_q) + k) % NUM_SLAVES;
      if (!win_found && bus.s_valid[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // Only the owner's done counts; other slaves' pulses are ignored.
  assign owner_done  = bus.s_tx_done[gid_q];
  assign cnt_expired = (cnt >= CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      gid_q   <= IDW'(NUM_SLAVES - 1);  // slave 0 searched first
      busy_q  <= 1'b0;
      te_q    <= 1'b0;
      cnt     <= '0;
    end else begin
      te_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state   <= XFER;
            grant_q <= ONE << win_id;
            gid_q   <= win_id;
            busy_q  <= 1'b1;
            cnt     <= '0;
          end
        end
        XFER: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          // Done takes priority over an expiring counter in the same cycle.
          if (owner_done || cnt_expired) begin
            state   <= RELEASE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            te_q    <= ~owner_done;
          end
        end
        RELEASE: state <= IDLE;  // grant_id kept as round-robin pointer
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // grant_q is non-zero only in XFER, so the lanes are naturally quiet
  // in IDLE/RELEASE and during reset.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_lane
    slave_tx_arbiter_lane u_lane (
      .gnt         (grant_q[i]),
      .m_ready     (bus.m_ready),
      .s_tx_data   (bus.s_tx_data[i]),
      .m_ready_out (mro[i]),
      .tx_bit      (tx_bits[i])
    );
  end

  assign bus.m_ready_out = mro;
  assign bus.tx_data     = |tx_bits;
  assign bus.grant       = grant_q;
  assign bus.grant_id    = gid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = te_q;
endmodule

// File: tb/tb_slave_tx_arbiter.sv
module tb_slave_tx_arbiter;
  localparam int N  = 3;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  slave_tx_arbiter_if #(.NUM_SLAVES(N)) bus ();

  slave_tx_arbiter #(.NUM_SLAVES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {grant, grant_id, busy, m_ready_out, tx_data, timeout_err}
  function automatic logic [10:0] dut_outs();
    return {bus.grant, bus.grant_id, bus.busy, bus.m_ready_out, bus.tx_data, bus.timeout_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_owner;  // -1 when nobody holds the line
  int m_last;   // round-robin pointer
  int m_age;    // XFER edges seen by current owner
  int m_gap;    // idle edges still to pass before arbitrating again
  bit m_to;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_age = 0; m_gap = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N-1:0] d);
    m_to = 0;
    if (m_owner >= 0) begin
      m_age++;
      if (d[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (m_age == TO) begin
        m_owner = -1; m_gap = 1; m_to = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (m_owner < 0 && v[idx]) begin
          m_owner = idx; m_last = idx; m_age = 0;
        end
      end
    end
  endtask

  function automatic logic [10:0] model_outs(input logic mr, input logic [N-1:0] x);
    logic [N-1:0] g;
    g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    return {g, 2'(m_last), (m_owner >= 0), (mr ? g : 3'b000), |(g & x), m_to};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0] v, d, x;
    logic       mr;
    logic [2:0] g;
    logic [1:0] gid;
    logic       b;
    logic [2:0] mro;
    logic       tx, te;
  } vec_t;

  vec_t tbl[16];

  task automatic drive(input logic [2:0] v, input logic [2:0] d, input logic [2:0] x, input logic mr);
    bus.s_valid = v; bus.s_tx_done = d; bus.s_tx_data = x; bus.m_ready = mr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(3'b000, 3'b000, 3'b000, 1'b1);
    model_reset();
    #1 chk("reset_state", 32'(dut_outs()), {21'd0, 3'b000, 2'd2, 1'b0, 3'b000, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs `late` = 0: no done -> timeout; `late` = 1: done in the 64th cycle.
  task automatic timeout_seq(input bit late);
    do_reset();
    @(negedge clk);
    drive(3'b001, 3'b000, 3'b000, 1'b1);
    @(posedge clk);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      drive(3'b000, (late && i == TO) ? 3'b001 : 3'b000, 3'b000, 1'b1);
      #1 chk(late ? "late_hold" : "to_hold", {30'd0, bus.busy, bus.timeout_err}, 32'b10);
    end
    @(negedge clk);
    drive(3'b000, 3'b000, 3'b000, 1'b1);
    #1 chk(late ? "late_release" : "to_release", {27'd0, bus.grant, bus.busy, bus.timeout_err},
           {27'd0, 3'b000, 1'b0, !late});
    @(negedge clk);
    #1 chk("to_pulse_end", {31'd0, bus.timeout_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] v, d, x;
    logic       mr;
    logic [7:0] pat;

    tbl[0]  = '{3'b111, 3'b000, 3'b000, 1'b1, 3'b000, 2'd2, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[1]  = '{3'b111, 3'b000, 3'b001, 1'b1, 3'b001, 2'd0, 1'b1, 3'b001, 1'b1, 1'b0};
    tbl[2]  = '{3'b110, 3'b000, 3'b000, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000, 1'b0, 1'b0};
    tbl[3]  = '{3'b110, 3'b010, 3'b001, 1'b1, 3'b001, 2'd0, 1'b1, 3'b001, 1'b1, 1'b0};
    tbl[4]  = '{3'b111, 3'b001, 3'b110, 1'b1, 3'b001, 2'd0, 1'b1, 3'b001, 1'b0, 1'b0};
    tbl[5]  = '{3'b111, 3'b000, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[6]  = '{3'b111, 3'b000, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[7]  = '{3'b111, 3'b000, 3'b010, 1'b1, 3'b010, 2'd1, 1'b1, 3'b010, 1'b1, 1'b0};
    tbl[8]  = '{3'b101, 3'b010, 3'b101, 1'b1, 3'b010, 2'd1, 1'b1, 3'b010, 1'b0, 1'b0};
    tbl[9]  = '{3'b101, 3'b000, 3'b000, 1'b1, 3'b000, 2'd1, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[10] = '{3'b101, 3'b000, 3'b000, 1'b1, 3'b000, 2'd1, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[11] = '{3'b101, 3'b000, 3'b100, 1'b1, 3'b100, 2'd2, 1'b1, 3'b100, 1'b1, 1'b0};
    tbl[12] = '{3'b101, 3'b100, 3'b000, 1'b1, 3'b100, 2'd2, 1'b1, 3'b100, 1'b0, 1'b0};
    tbl[13] = '{3'b101, 3'b000, 3'b000, 1'b1, 3'b000, 2'd2, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[14] = '{3'b101, 3'b000, 3'b000, 1'b1, 3'b000, 2'd2, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[15] = '{3'b101, 3'b000, 3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000, 1'b1, 1'b0};

    drive(3'b000, 3'b000, 3'b000, 1'b1);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].d, tbl[i].x, tbl[i].mr);
      #1 chk($sformatf("table[%0d]", i), 32'(dut_outs()),
             32'({tbl[i].g, tbl[i].gid, tbl[i].b, tbl[i].mro, tbl[i].tx, tbl[i].te}));
    end

    // Owner 1 streams a pattern; a stray done from slave 0 must not end it.
    do_reset();
    @(negedge clk);
    drive(3'b010, 3'b000, 3'b000, 1'b1);
    pat = 8'b1010_0100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      x = {!pat[7-i], pat[7-i], !pat[7-i]};
      drive(3'b000, (i == 3) ? 3'b001 : 3'b000, x, 1'b1);
      #1 chk($sformatf("pattern[%0d]", i), {28'd0, bus.grant, bus.tx_data}, {28'd0, 3'b010, pat[7-i]});
    end

    timeout_seq(1'b0);
    timeout_seq(1'b1);

    // Asynchronous reset in the middle of a low clock phase.
    do_reset();
    @(negedge clk);
    drive(3'b001, 3'b000, 3'b000, 1'b1);
    @(negedge clk);
    #1 chk("async_pre", {29'd0, bus.grant}, 32'b001);
    #2 rst = 1'b1;
    #1 chk("async_rst", {25'd0, bus.grant, bus.busy, bus.m_ready_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b110, 3'b000, 3'b000, 1'b1);
    @(posedge clk);
    #1 chk("async_after", {27'd0, bus.grant, bus.grant_id}, {27'd0, 3'b010, 2'd1});

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      v  = ($urandom_range(3) == 0) ? 3'b000 : 3'($urandom);
      d  = {($urandom_range(15) == 0), ($urandom_range(15) == 0), ($urandom_range(15) == 0)};
      x  = 3'($urandom);
      mr = 1'($urandom);
      drive(v, d, x, mr);
      #1 chk($sformatf("rand[%0d]", c), 32'(dut_outs()), 32'(model_outs(mr, x)));
      @(posedge clk);
      model_step(v, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
